alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width; SHALL match the ALU datapath width.
REQ-002 Parameter SEL_W, default 3, ALU opcode width.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 REQ0_VALID / REQ1_VALID  input  1 each  request valid, port 0 / port 1.
REQ-006 REQ0_READY / REQ1_READY  output  1 each  request accepted this cycle.
REQ-007 REQ0_OP / REQ1_OP  input  SEL_W each  opcode: 000 forward DATA2, 001 add, 010 and, 011 or.
REQ-008 REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  DATA_W each  operands.
REQ-009 RSP0_VALID / RSP1_VALID  output  1 each  result valid.
REQ-010 RSP0_READY / RSP1_READY  input  1 each  requester takes result.
REQ-011 RSP_DATA  output  DATA_W  result; shared by both ports, qualified by RSPx_VALID.
REQ-012 RSP_ERR  output  1  illegal opcode flag, qualified by RSPx_VALID.
REQ-013 ALU_DATA1, ALU_DATA2  output  DATA_W  operands to the shared ALU.
REQ-014 ALU_SELECT  output  SEL_W  opcode to the shared ALU.
REQ-015 ALU_RESULT  input  DATA_W  combinational ALU result.

Function
REQ-016 FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any REQx_VALID is high, the block SHALL grant one port, assert that port's REQx_READY in the same cycle, register OP/A/B and the grant ID, and go to EXEC.
REQ-018 REQx_READY SHALL be low in EXEC and RESP and for the non-granted port.
REQ-019 Arbitration SHALL be round-robin: when both ports are valid, the port not granted last SHALL win; a single valid port SHALL always win; the last-grant pointer SHALL update only on acceptance.
REQ-020 EXEC: ALU_DATA1/ALU_DATA2/ALU_SELECT SHALL drive the registered operands for one cycle; ALU_RESULT SHALL be captured into RSP_DATA at the end of EXEC; next state RESP.
REQ-021 Opcodes 100-111 SHALL be accepted but not sent to the ALU: ALU_SELECT SHALL stay 000; RSP_DATA SHALL be 0x00 and RSP_ERR 1.
REQ-022 RESP: only the granted port's RSPx_VALID SHALL be high; RSP_DATA/RSP_ERR SHALL be stable until RSPx_READY is sampled high; then the block SHALL go to IDLE.
REQ-023 Latency: accept edge to RSPx_VALID high SHALL be 2 cycles; best-case throughput is one operation per 3 cycles.
REQ-024 Requests arriving in EXEC/RESP SHALL wait (VALID held by requester) and SHALL not be dropped.
REQ-025 Add SHALL be modulo 2^DATA_W; carry is discarded.
REQ-026 Outside EXEC, ALU_DATA1/ALU_DATA2/ALU_SELECT SHALL hold their last driven values (no glitch to the ALU).

Reset
REQ-027 On RESETN low, immediately: state IDLE; REQx_READY 0; RSPx_VALID 0; RSP_DATA 0x00; RSP_ERR 0; ALU_DATA1/ALU_DATA2 0x00; ALU_SELECT 000; last-grant pointer = port 1, so port 0 wins the first tie.
REQ-028 Reset asserted mid-operation SHALL abort the operation; no response SHALL be issued for it after reset is released.
REQ-029 Reset deassertion SHALL take effect on the next CLK rising edge; the first acceptance SHALL be possible in that cycle.

Structure
REQ-030 A shared package SHALL hold the opcode constants (OP_FWD, OP_ADD, OP_AND, OP_OR), the FSM state encoding, DATA_W and SEL_W.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arb2.
REQ-032 The ALU SHALL be external to this block; the bench SHALL instantiate the existing ALU and connect it to the ALU_* ports.

Verification
REQ-033 Reset mid-EXEC -> all outputs reach their reset values with no clock edge; no RSPx_VALID after release.
REQ-034 Port 0 alone, OP=001, A=0x0F, B=0x01 -> REQ0_READY at cycle 0; RSP0_VALID at cycle 2; RSP_DATA=0x10; RSP_ERR=0.
REQ-035 Both ports valid continuously after reset, port 0 OP=011 A=0xF0 B=0x0F, port 1 OP=010 A=0xAA B=0x0F -> grants alternate 0,1,0,1; responses 0xFF, 0x0A, 0xFF, 0x0A.
REQ-036 Port 1, OP=001, A=0xFF, B=0x02 -> RSP_DATA=0x01 (wrap-around).
REQ-037 Port 0 OP=101 -> ALU_SELECT stays 000; RSP_DATA=0x00; RSP_ERR=1.
REQ-038 RSP1_READY held low for 5 cycles -> RSP1_VALID and RSP_DATA stable throughout; a pending REQ0_VALID is not accepted until the cycle after RSP1_READY goes high.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-port ALU arbiter: widths, opcodes, FSM encoding.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP_FWD = 3'b000;
    localparam logic [SEL_W-1:0] OP_ADD = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Anything above OP_OR is accepted but answered with an error, never executed.
    function automatic logic op_is_legal(input logic [SEL_W-1:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the last-grant pointer moves only when a grant is issued.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
            else                gnt_o = req_i;
        end
    end

    assign gnt_id_o = gnt_o[1];

    // Reset points at port 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     last_q <= 1'b1;
        else if (|gnt_o) last_q <= gnt_o[1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two request/response ports (IDLE -> EXEC -> RESP).
module alu_arbiter #(
    parameter int DATA_W = alu_arbiter_pkg::DATA_W,
    parameter int SEL_W  = alu_arbiter_pkg::SEL_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [SEL_W-1:0]  req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [SEL_W-1:0]  req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [SEL_W-1:0]  alu_select_o,
    input  logic [DATA_W-1:0] alu_result_i
);

    import alu_arbiter_pkg::*;

    state_e            state_q, state_d;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic              acc_en;
    logic              gnt_q;
    logic              err_q;
    logic [SEL_W-1:0]  acc_op;
    logic [DATA_W-1:0] acc_a, acc_b;
    logic              rsp_take;
    logic [DATA_W-1:0] alu_d1_q, alu_d2_q, rsp_data_q;
    logic [SEL_W-1:0]  alu_sel_q;
    logic              rsp_err_q;

    // Grants are masked while reset is held so READY stays low immediately.
    assign acc_en = (state_q == ST_IDLE) && rst_ni;

    rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    ({req1_valid_i, req0_valid_i}),
        .en_i     (acc_en),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign acc_op   = gnt_id ? req1_op_i : req0_op_i;
    assign acc_a    = gnt_id ? req1_a_i  : req0_a_i;
    assign acc_b    = gnt_id ? req1_b_i  : req0_b_i;
    assign rsp_take = gnt_q  ? rsp1_ready_i : rsp0_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        req0_ready_o = gnt[0];
        req1_ready_o = gnt[1];
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;
        unique case (state_q)
            ST_IDLE: if (|gnt) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                rsp0_valid_o = !gnt_q;
                rsp1_valid_o = gnt_q;
                if (rsp_take) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU operand registers double as the request capture; illegal ops leave
    // the operands untouched and park the select at OP_FWD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q      <= 1'b0;
            err_q      <= 1'b0;
            alu_d1_q   <= '0;
            alu_d2_q   <= '0;
            alu_sel_q  <= OP_FWD;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (|gnt) begin
                gnt_q <= gnt_id;
                err_q <= !op_is_legal(acc_op);
                if (op_is_legal(acc_op)) begin
                    alu_d1_q  <= acc_a;
                    alu_d2_q  <= acc_b;
                    alu_sel_q <= acc_op;
                end else begin
                    alu_sel_q <= OP_FWD;
                end
            end
            if (state_q == ST_EXEC) begin
                rsp_data_q <= err_q ? '0 : alu_result_i;
                rsp_err_q  <= err_q;
            end
        end
    end

    assign alu_data1_o  = alu_d1_q;
    assign alu_data2_o  = alu_d2_q;
    assign alu_select_o = alu_sel_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model, directed scenarios and random traffic.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       v0, v1, rr0, rr1;
    logic [2:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       r0, r1, rv0, rv1, rerr;
    logic [7:0] rdata, ad1, ad2, ares;
    logic [2:0] asel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .SEL_W(3)) dut (
        .clk_i(clk), .rst_ni(rstn),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
        .rsp0_valid_o(rv0), .rsp0_ready_i(rr0), .rsp1_valid_o(rv1), .rsp1_ready_i(rr1),
        .rsp_data_o(rdata), .rsp_err_o(rerr),
        .alu_data1_o(ad1), .alu_data2_o(ad2), .alu_select_o(asel), .alu_result_i(ares)
    );

    // The shared ALU sitting outside the arbiter.
    always_comb begin
        ares = 8'h00;
        case (asel)
            3'b000: ares = ad2;
            3'b001: ares = ad1 + ad2;
            3'b010: ares = ad1 & ad2;
            3'b011: ares = ad1 | ad2;
            default: ares = 8'h00;
        endcase
    end

    // Reference model: one outstanding operation, aged in cycles since acceptance.
    bit         m_busy;
    int         m_age;
    int         m_port;
    int         m_last;
    logic [7:0] m_data, m_d1, m_d2;
    logic       m_err;
    logic [2:0] m_sel;

    logic       o_rdy0, o_rdy1, o_rv0, o_rv1, o_err;
    logic [7:0] o_data;
    logic [2:0] o_sel;
    int         gq[$];
    logic [7:0] dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_age = 0; m_port = 0; m_last = 1;
        m_data = 8'h00; m_err = 1'b0; m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'b000;
    endfunction

    task automatic check_cycle();
        int         g;
        logic [2:0] op;
        logic [7:0] a, b;
        g = -1;
        if (!m_busy) begin
            if (v0 && v1) g = (m_last == 1) ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        chk("req0_ready", r0, g == 0);
        chk("req1_ready", r1, g == 1);
        chk("rsp0_valid", rv0, m_busy && m_age >= 2 && m_port == 0);
        chk("rsp1_valid", rv1, m_busy && m_age >= 2 && m_port == 1);
        if (m_busy && m_age >= 2) begin
            chk("rsp_data", rdata, m_data);
            chk("rsp_err", rerr, m_err);
        end
        chk("alu_data1", ad1, m_d1);
        chk("alu_data2", ad2, m_d2);
        chk("alu_select", asel, m_sel);

        o_rdy0 = r0; o_rdy1 = r1; o_rv0 = rv0; o_rv1 = rv1;
        o_data = rdata; o_err = rerr; o_sel = asel;
        if (r0) gq.push_back(0);
        if (r1) gq.push_back(1);
        if ((rv0 && rr0) || (rv1 && rr1)) dq.push_back(rdata);

        if (g >= 0) begin
            op = (g == 1) ? op1 : op0;
            a  = (g == 1) ? a1  : a0;
            b  = (g == 1) ? b1  : b0;
            m_busy = 1; m_age = 1; m_port = g; m_last = g;
            if (op <= 3'd3) begin
                m_err = 1'b0; m_d1 = a; m_d2 = b; m_sel = op;
                case (op)
                    3'd0:    m_data = b;
                    3'd1:    m_data = 8'((int'(a) + int'(b)) % 256);
                    3'd2:    m_data = a & b;
                    default: m_data = a | b;
                endcase
            end else begin
                m_err = 1'b1; m_data = 8'h00; m_sel = 3'b000;
            end
        end else if (m_busy) begin
            if (m_age >= 2 && ((m_port == 1) ? rr1 : rr0)) m_busy = 0;
            else m_age++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
    endtask

    task automatic wait_accept(input int port, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = (port == 1) ? o_rdy1 : o_rdy0;
        end
        chk(name, got, 1);
    endtask

    task automatic wait_rsp(input int port, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (port == 1) ? o_rv1 : o_rv0;
        end
        chk(name, got, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        logic [7:0] exp_d[4];
        exp_g = '{0, 1, 0, 1};
        exp_d = '{8'hFF, 8'h0A, 8'hFF, 8'h0A};

        rstn = 1'b0;
        v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        rr0 = 1; rr1 = 1;
        model_reset();
        #3;
        chk("reset_rsp_valid", {rv1, rv0}, 2'b00);
        chk("reset_ready", {r1, r0}, 2'b00);
        chk("reset_rsp_data", rdata, 8'h00);
        chk("reset_alu", {ad1, ad2, asel}, 19'h0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Port 0 add: accepted in cycle 0, response in cycle 2.
        v0 = 1; op0 = 3'b001; a0 = 8'h0F; b0 = 8'h01;
        tick();
        chk("t_add_ready_c0", o_rdy0, 1);
        v0 = 0;
        tick();
        chk("t_add_valid_c1", o_rv0, 0);
        tick();
        chk("t_add_valid_c2", o_rv0, 1);
        chk("t_add_data", o_data, 8'h10);
        chk("t_add_err", o_err, 0);

        // Continuous contention straight after reset alternates grants.
        do_reset();
        gq.delete(); dq.delete();
        v0 = 1; op0 = 3'b011; a0 = 8'hF0; b0 = 8'h0F;
        v1 = 1; op1 = 3'b010; a1 = 8'hAA; b1 = 8'h0F;
        repeat (12) tick();
        v0 = 0; v1 = 0;
        chk("t_rr_ngrants", gq.size() >= 4, 1);
        chk("t_rr_nrsp", dq.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk($sformatf("t_rr_grant%0d", i), gq[i], exp_g[i]);
            if (i < dq.size()) chk($sformatf("t_rr_data%0d", i), dq[i], exp_d[i]);
        end
        tick();

        // Port 1 add wraps modulo 256.
        v1 = 1; op1 = 3'b001; a1 = 8'hFF; b1 = 8'h02;
        wait_accept(1, "t_wrap_accept");
        v1 = 0;
        wait_rsp(1, "t_wrap_rsp");
        chk("t_wrap_data", o_data, 8'h01);

        // Illegal opcode: never reaches the ALU, answered with error.
        v0 = 1; op0 = 3'b101; a0 = 8'h12; b0 = 8'h34;
        wait_accept(0, "t_ill_accept");
        v0 = 0;
        tick();
        chk("t_ill_select", o_sel, 3'b000);
        wait_rsp(0, "t_ill_rsp");
        chk("t_ill_data", o_data, 8'h00);
        chk("t_ill_err", o_err, 1);

        // Back-pressure on port 1 while port 0 waits.
        rr1 = 0;
        v1 = 1; op1 = 3'b010; a1 = 8'h3C; b1 = 8'hF0;
        wait_accept(1, "t_bp_accept");
        v1 = 0;
        v0 = 1; op0 = 3'b000; a0 = 8'h00; b0 = 8'h55;
        tick();
        chk("t_bp_exec_ready0", o_rdy0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t_bp_hold_valid", o_rv1, 1);
            chk("t_bp_hold_data", o_data, 8'h30);
            chk("t_bp_hold_ready0", o_rdy0, 0);
        end
        rr1 = 1;
        tick();
        chk("t_bp_release_ready0", o_rdy0, 0);
        tick();
        chk("t_bp_next_ready0", o_rdy0, 1);
        v0 = 0;
        wait_rsp(0, "t_bp_rsp0");
        chk("t_bp_fwd_data", o_data, 8'h55);

        // Reset in the middle of EXEC aborts the operation.
        v0 = 1; op0 = 3'b001; a0 = 8'h03; b0 = 8'h04;
        wait_accept(0, "t_rst_accept");
        #2 rstn = 1'b0;
        #1;
        chk("t_rst_ready", {r1, r0}, 2'b00);
        chk("t_rst_rsp_valid", {rv1, rv0}, 2'b00);
        chk("t_rst_rsp", {rdata, rerr}, 9'h0);
        chk("t_rst_alu", {ad1, ad2, asel}, 19'h0);
        v0 = 0;
        @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t_rst_no_rsp", {o_rv1, o_rv0}, 2'b00);
        end

        // Random traffic; requesters hold VALID until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!v0 || o_rdy0) begin
                v0 = ($urandom_range(0, 2) != 0);
                op0 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
                a0 = 8'($urandom); b0 = 8'($urandom);
            end
            if (!v1 || o_rdy1) begin
                v1 = ($urandom_range(0, 2) != 0);
                op1 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
                a1 = 8'($urandom); b1 = 8'($urandom);
            end
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            tick();
        end
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
